fetch_unit: RTL and testbench

Instruction fetch front end that produces the instruction word and PC consumed by the decode stage.
- Owns the architectural fetch PC and issues word reads to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions, tagged with their PCs, in a small FIFO drained by decode through a valid/ready handshake.
- Accepts redirects from branch/jump resolution, flushing buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_unit_chk.sv | 47 ++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
//   NOP_INST        - instruction presented to decode when nothing is buffered
//   INST_W          - instruction / address width
//   fetch_entry_t   - buffered instruction tagged with its PC
//   cnt_width()     - width of a counter that must hold 0..max_val
package fetch_pkg;

    localparam int          INST_W   = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [INST_W-1:0] pc;
    } fetch_entry_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Counter widths for the default configuration (2 outstanding, 2 buffered).
    localparam int DEF_OUT_CNT_W  = cnt_width(2);
    localparam int DEF_FIFO_CNT_W = cnt_width(2);

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory bus between the fetch unit and imem.
//   o_imem_req_valid / i_imem_req_ready / o_imem_req_addr : request channel
//   i_imem_rsp_valid / i_imem_rsp_data                    : in-order response,
//                                                           no backpressure
// Signal prefixes are from the fetch unit's point of view.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic              o_imem_req_valid;
    logic              i_imem_req_ready;
    logic [INST_W-1:0] o_imem_req_addr;
    logic              i_imem_rsp_valid;
    logic [INST_W-1:0] i_imem_rsp_data;

    modport master (
        output o_imem_req_valid,
        output o_imem_req_addr,
        input  i_imem_req_ready,
        input  i_imem_rsp_valid,
        input  i_imem_rsp_data
    );

    modport slave (
        input  o_imem_req_valid,
        input  o_imem_req_addr,
        output i_imem_req_ready,
        output i_imem_rsp_valid,
        output i_imem_rsp_data
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO used both as the instruction buffer and as the
// PC tag queue of in-flight requests.
//   clk, rst     - clock, asynchronous active-high reset
//   i_push       - write i_push_data (ignored when full)
//   i_pop        - drop the head entry (ignored when empty)
//   i_flush      - discard all entries; wins over push and pop
//   o_head       - head entry (undefined content when o_count == 0)
//   o_count      - number of valid entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign w_push  = i_push && (r_count != CNT_W'(DEPTH));
    assign w_pop   = i_pop && (r_count != {CNT_W{1'b0}});
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= {PTR_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (i_flush) begin
            r_rd_ptr <= {PTR_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful below r_count so no reset.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/fetch_unit_chk.sv
// fetch_unit_chk: protocol checker for the imem bus of fetch_unit.
// Tracks requests in flight from the bus alone and flags responses that have
// no matching request, misaligned addresses and exceeding the in-flight limit.
//   clk, rst       - clock, asynchronous active-high reset
//   i_req_valid    - o_imem_req_valid
//   i_req_ready    - i_imem_req_ready
//   i_req_addr_lo  - o_imem_req_addr[1:0]
//   i_rsp_valid    - i_imem_rsp_valid
module fetch_unit_chk #(
    parameter int MAX_OUTSTANDING = 2
) (
    input logic       clk,
    input logic       rst,
    input logic       i_req_valid,
    input logic       i_req_ready,
    input logic [1:0] i_req_addr_lo,
    input logic       i_rsp_valid
);

    logic [7:0] r_pending;
    logic       w_fire;
    logic       w_rsp_ok;

    assign w_fire   = i_req_valid && i_req_ready;
    assign w_rsp_ok = i_rsp_valid && (r_pending != 8'd0);

    // Requests accepted minus responses returned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 8'd0;
        end else begin
            case ({w_fire, w_rsp_ok})
                2'b10:   r_pending <= r_pending + 8'd1;
                2'b01:   r_pending <= r_pending - 8'd1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
        i_rsp_valid |-> (r_pending != 8'd0));
    a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
        i_req_valid |-> (i_req_addr_lo == 2'b00));
    a_inflight_bound: assert property (@(posedge clk) disable iff (rst)
        r_pending <= 8'(MAX_OUTSTANDING));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end feeding the decode stage.
// Owns the fetch PC, issues word reads over imem_bus, buffers returned words
// tagged with their PC and hands them to decode; redirects flush the buffer
// and discard every response still in flight.
//   clk, rst        - clock, asynchronous active-high reset
//   imem_bus        - instruction memory request/response bus (master side)
//   i_redirect      - single-cycle redirect pulse, target in i_redirect_pc
//   o_inst_valid / i_inst_ready / o_inst / o_inst_pc - decode handshake
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst,
    fetch_unit_if.master      imem_bus,
    input  logic              i_redirect,
    input  logic [INST_W-1:0] i_redirect_pc,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [INST_W-1:0] o_inst,
    output logic [INST_W-1:0] o_inst_pc
);

    localparam int OCW = cnt_width(MAX_OUTSTANDING);
    localparam int FCW = cnt_width(FIFO_DEPTH);

    logic              r_run;
    logic [31:0]       r_fetch_pc;
    logic [OCW-1:0]    r_drop_count;

    // The tag queue holds one PC per request in flight, so its occupancy is
    // the outstanding-request count.
    logic [OCW-1:0]    w_outstanding;
    logic [31:0]       w_tag_pc;
    logic [FCW-1:0]    w_fifo_count;
    fetch_entry_t      w_head;
    fetch_entry_t      w_push_entry;
    logic [31:0]       w_inflight;
    logic              w_req_valid;
    logic              w_req_fire;
    logic              w_rsp_ok;
    logic              w_rsp_keep;
    logic [OCW-1:0]    w_out_after_rsp;
    logic              w_fifo_empty;

    // Credit rule: in-flight plus buffered never exceeds the buffer, so every
    // response is guaranteed a slot and responses need no backpressure.
    assign w_inflight  = 32'(w_outstanding) + 32'(w_fifo_count);
    assign w_req_valid = r_run && !i_redirect
                         && (w_inflight < 32'(FIFO_DEPTH))
                         && (32'(w_outstanding) < 32'(MAX_OUTSTANDING));
    assign w_req_fire  = w_req_valid && imem_bus.i_imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp_ok        = imem_bus.i_imem_rsp_valid && (w_outstanding != {OCW{1'b0}});
    assign w_rsp_keep      = w_rsp_ok && !i_redirect && (r_drop_count == {OCW{1'b0}});
    assign w_out_after_rsp = w_outstanding - OCW'(w_rsp_ok);

    assign w_push_entry.inst = imem_bus.i_imem_rsp_data;
    assign w_push_entry.pc   = w_tag_pc;

    assign w_fifo_empty = (w_fifo_count == {FCW{1'b0}});

    assign imem_bus.o_imem_req_valid = w_req_valid;
    assign imem_bus.o_imem_req_addr  = r_fetch_pc;

    assign o_inst_valid = !w_fifo_empty && !i_redirect;
    assign o_inst       = w_fifo_empty ? NOP_INST : w_head.inst;
    assign o_inst_pc    = w_fifo_empty ? 32'h0000_0000 : w_head.pc;

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_q (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_req_fire),
        .i_push_data (r_fetch_pc),
        .i_pop       (w_rsp_ok),
        .i_flush     (1'b0),
        .o_head      (w_tag_pc),
        .o_count     (w_outstanding)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_q (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_rsp_keep),
        .i_push_data (w_push_entry),
        .i_pop       (o_inst_valid && i_inst_ready),
        .i_flush     (i_redirect),
        .o_head      (w_head),
        .o_count     (w_fifo_count)
    );

    // Fetch PC, post-reset start flag and count of responses to discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run        <= 1'b0;
            r_fetch_pc   <= RESET_PC;
            r_drop_count <= {OCW{1'b0}};
        end else begin
            r_run <= 1'b1;
            if (i_redirect) begin
                // Everything still in flight after this cycle's response is stale.
                r_fetch_pc   <= {i_redirect_pc[31:2], 2'b00};
                r_drop_count <= w_out_after_rsp;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_rsp_ok && (r_drop_count != {OCW{1'b0}})) begin
                    r_drop_count <= r_drop_count - OCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// A small imem model answers requests in order with data = addr ^ 13579BDF,
// one cycle after acceptance while enabled. Inputs change 1 time unit after
// the rising edge; observations are taken on the falling edge.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        mem_en;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] pend[$];
    logic [31:0] req_addrs[$];
    logic [31:0] pop_pcs[$];
    logic        fire_s;
    logic [31:0] fire_addr;

    fetch_unit_if bus();

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC        (32'h0000_0000),
        .FIFO_DEPTH      (2),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_bus      (bus),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_inst_valid  (inst_valid),
        .i_inst_ready  (inst_ready),
        .o_inst        (inst),
        .o_inst_pc     (inst_pc)
    );

    fetch_unit_chk #(
        .MAX_OUTSTANDING (2)
    ) chk (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (bus.o_imem_req_valid),
        .i_req_ready   (bus.i_imem_req_ready),
        .i_req_addr_lo (bus.o_imem_req_addr[1:0]),
        .i_rsp_valid   (bus.i_imem_rsp_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Mid-cycle monitor: records accepted requests and decode pops.
    always @(negedge clk) begin
        fire_s    = !rst && bus.o_imem_req_valid && bus.i_imem_req_ready;
        fire_addr = bus.o_imem_req_addr;
        if (fire_s) req_addrs.push_back(fire_addr);
        if (!rst && inst_valid && inst_ready) begin
            pop_pcs.push_back(inst_pc);
            check_value("pop_data", inst, mem_word(inst_pc));
        end
    end

    // Instruction memory model; reset together with the DUT.
    always @(posedge clk) begin : imem_model
        logic [31:0] a;
        #2;
        if (rst) begin
            pend.delete();
            bus.i_imem_rsp_valid = 1'b0;
            bus.i_imem_rsp_data  = 32'h0;
        end else begin
            if (fire_s) pend.push_back(fire_addr);
            if (mem_en && pend.size() > 0) begin
                a = pend.pop_front();
                bus.i_imem_rsp_valid = 1'b1;
                bus.i_imem_rsp_data  = mem_word(a);
            end else begin
                bus.i_imem_rsp_valid = 1'b0;
                bus.i_imem_rsp_data  = 32'h0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic req_rdy, input logic dec_rdy, input logic en);
        rst                  = 1'b1;
        redirect             = 1'b0;
        redirect_pc          = 32'h0;
        bus.i_imem_req_ready = req_rdy;
        inst_ready           = dec_rdy;
        mem_en               = en;
        tick(2);
        req_addrs.delete();
        pop_pcs.delete();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        req_addrs.delete();
        pop_pcs.delete();
    endtask

    initial begin
        rst                  = 1'b1;
        redirect             = 1'b0;
        redirect_pc          = 32'h0;
        inst_ready           = 1'b1;
        bus.i_imem_req_ready = 1'b1;
        mem_en               = 1'b1;

        // Reset values.
        @(negedge clk);
        check_value("rst_req_valid",  32'(bus.o_imem_req_valid), 32'd0);
        check_value("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_value("rst_inst",       inst, 32'h0000_0013);
        check_value("rst_inst_pc",    inst_pc, 32'h0);

        // Streaming fetch from RESET_PC.
        do_reset(1'b1, 1'b1, 1'b1);
        tick(8);
        check_value("t1_req0", qget(req_addrs, 0), 32'h0);
        check_value("t1_req1", qget(req_addrs, 1), 32'h4);
        check_value("t1_req2", qget(req_addrs, 2), 32'h8);
        check_value("t1_pop0", qget(pop_pcs, 0), 32'h0);
        check_value("t1_pop1", qget(pop_pcs, 1), 32'h4);
        check_value("t1_pop2", qget(pop_pcs, 2), 32'h8);

        // Decode stall fills the buffer and stops requests.
        do_reset(1'b1, 1'b0, 1'b1);
        tick(8);
        @(negedge clk);
        check_value("t2_nreq",       32'(req_addrs.size()), 32'd2);
        check_value("t2_req_valid",  32'(bus.o_imem_req_valid), 32'd0);
        check_value("t2_inst_valid", 32'(inst_valid), 32'd1);
        check_value("t2_head_pc",    inst_pc, 32'h0);
        tick(1);
        inst_ready = 1'b1;
        tick(8);
        check_value("t2_req2", qget(req_addrs, 2), 32'h8);
        check_value("t2_pop0", qget(pop_pcs, 0), 32'h0);
        check_value("t2_pop1", qget(pop_pcs, 1), 32'h4);
        check_value("t2_pop2", qget(pop_pcs, 2), 32'h8);
        check_value("t2_pop3", qget(pop_pcs, 3), 32'hC);

        // Two requests in flight, then a redirect drops both responses.
        do_reset(1'b0, 1'b1, 1'b0);
        tick(2);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0010;
        @(negedge clk);
        check_value("t3_rdr_req_valid", 32'(bus.o_imem_req_valid), 32'd0);
        tick(1);
        redirect             = 1'b0;
        bus.i_imem_req_ready = 1'b1;
        tick(5);
        @(negedge clk);
        check_value("t3_nreq",      32'(req_addrs.size()), 32'd2);
        check_value("t3_req0",      qget(req_addrs, 0), 32'h10);
        check_value("t3_req1",      qget(req_addrs, 1), 32'h14);
        check_value("t3_req_valid", 32'(bus.o_imem_req_valid), 32'd0);
        tick(1);
        clear_logs();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        check_value("t3_rdr_inst_valid", 32'(inst_valid), 32'd0);
        tick(1);
        redirect = 1'b0;
        mem_en   = 1'b1;
        tick(8);
        check_value("t3_req_after", qget(req_addrs, 0), 32'h200);
        check_value("t3_pop_after", qget(pop_pcs, 0), 32'h200);

        // Redirect coinciding with a response and decode ready.
        do_reset(1'b1, 1'b1, 1'b1);
        tick(6);
        clear_logs();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        check_value("t4_rsp_present", 32'(bus.i_imem_rsp_valid), 32'd1);
        check_value("t4_inst_valid",  32'(inst_valid), 32'd0);
        check_value("t4_req_valid",   32'(bus.o_imem_req_valid), 32'd0);
        tick(1);
        redirect = 1'b0;
        tick(6);
        check_value("t4_req0", qget(req_addrs, 0), 32'h200);
        check_value("t4_pop0", qget(pop_pcs, 0), 32'h200);

        // Back-to-back redirects; misaligned target is aligned down.
        tick(2);
        clear_logs();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick(1);
        redirect_pc = 32'h0000_0203;
        tick(1);
        redirect = 1'b0;
        tick(6);
        check_value("t5_req0", qget(req_addrs, 0), 32'h200);
        check_value("t5_pop0", qget(pop_pcs, 0), 32'h200);
        check_value("t5_pop1", qget(pop_pcs, 1), 32'h204);

        // Fetch PC wraps past the top of the address space.
        clear_logs();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick(1);
        redirect = 1'b0;
        tick(6);
        check_value("t5_wrap_req0", qget(req_addrs, 0), 32'hFFFF_FFFC);
        check_value("t5_wrap_req1", qget(req_addrs, 1), 32'h0);
        check_value("t5_wrap_pop1", qget(pop_pcs, 1), 32'h0);

        // Reset asserted mid-stream with requests outstanding.
        do_reset(1'b1, 1'b1, 1'b0);
        tick(5);
        check_value("t6_nreq", 32'(req_addrs.size()), 32'd2);
        inst_ready = 1'b0;
        mem_en     = 1'b1;
        tick(1);
        mem_en = 1'b0;
        tick(2);
        @(negedge clk);
        check_value("t6_pre_inst_valid", 32'(inst_valid), 32'd1);
        check_value("t6_pre_inst_pc",    inst_pc, 32'h0);
        tick(1);
        rst = 1'b1;
        #1;
        check_value("t6_rst_req_valid",  32'(bus.o_imem_req_valid), 32'd0);
        check_value("t6_rst_inst_valid", 32'(inst_valid), 32'd0);
        check_value("t6_rst_inst",       inst, 32'h0000_0013);
        check_value("t6_rst_inst_pc",    inst_pc, 32'h0);
        tick(2);
        clear_logs();
        mem_en     = 1'b1;
        inst_ready = 1'b1;
        rst        = 1'b0;
        tick(8);
        check_value("t6_req0", qget(req_addrs, 0), 32'h0);
        check_value("t6_pop0", qget(pop_pcs, 0), 32'h0);
        check_value("t6_pop1", qget(pop_pcs, 1), 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
